// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared Breakout screen/brick geometry, game FSM encoding and helpers
package breakout_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int TOP_Y      = 32;
    localparam int LAVA_Y     = 448;
    localparam int BLK_W_LG2  = 6;
    localparam int BLK_H_LG2  = 4;
    localparam int BRICK_COLS = 8;
    localparam int BRICK_ROWS = 4;
    localparam int DESCENT_TK = 600;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/cell_locator.sv
// rtl/cell_locator.sv - maps a screen point and wall offset to brick row/col; shared with the renderer
module cell_locator #(
    parameter int COLS      = breakout_pkg::BRICK_COLS,
    parameter int ROWS      = breakout_pkg::BRICK_ROWS,
    parameter int BLK_W_LG2 = breakout_pkg::BLK_W_LG2,
    parameter int BLK_H_LG2 = breakout_pkg::BLK_H_LG2,
    parameter int TOP_Y     = breakout_pkg::TOP_Y,
    parameter int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int COL_W     = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic [9:0]       i_x,
    input  logic [9:0]       i_y,
    input  logic [9:0]       i_off,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_in_field
);
    import breakout_pkg::*;

    // One extra bit beyond the 11-bit signed range keeps the sign exact for every y/off pair.
    logic [11:0] w_dy;

    assign w_dy       = {2'b00, i_y} - 12'(TOP_Y) - {2'b00, i_off};
    assign o_row      = ROW_W'(w_dy[10:0] >> BLK_H_LG2);
    assign o_col      = COL_W'(i_x >> BLK_W_LG2);
    assign o_in_field = !w_dy[11]
                        && (w_dy[10:0] < 11'(ROWS << BLK_H_LG2))
                        && (i_x < 10'(COLS << BLK_W_LG2));

endmodule

// File: rtl/brick_field.sv
// rtl/brick_field.sv - Breakout brick wall: occupancy bitmap, periodic descent, ball hits, lava endgame
module brick_field #(
    parameter int COLS       = breakout_pkg::BRICK_COLS,
    parameter int ROWS       = breakout_pkg::BRICK_ROWS,
    parameter int BLK_W_LG2  = breakout_pkg::BLK_W_LG2,
    parameter int BLK_H_LG2  = breakout_pkg::BLK_H_LG2,
    parameter int TOP_Y      = breakout_pkg::TOP_Y,
    parameter int LAVA_Y     = breakout_pkg::LAVA_Y,
    parameter int DESCENT_TK = breakout_pkg::DESCENT_TK
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 frame_tick,
    input  logic                 ball_valid,
    input  logic [9:0]           ball_x,
    input  logic [9:0]           ball_y,
    output logic                 hit_block,
    output logic                 bounce_y,
    output logic                 endgame_block,
    output logic [ROWS*COLS-1:0] bricks,
    output logic [9:0]           field_off,
    output logic [5:0]           bricks_left
);
    import breakout_pkg::*;

    localparam int N        = ROWS * COLS;
    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W    = (DESCENT_TK > 1) ? $clog2(DESCENT_TK) : 1;
    localparam int STEP     = 1 << BLK_H_LG2;

    state_t           r_state;
    logic [N-1:0]     r_bricks;
    logic [9:0]       r_off;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cap_valid;
    logic [9:0]       r_cap_x;
    logic [9:0]       r_cap_y;
    logic [9:0]       r_cap_off;
    logic             r_hit;
    logic             r_endgame;

    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_col;
    logic             w_in_field;
    logic [IDX_W-1:0] w_idx;
    logic [N-1:0]     w_mask;
    logic             w_hit;
    logic [5:0]       w_left;
    logic [9:0]       w_off_next;
    logic             w_any;
    logic [ROW_W-1:0] w_lowest;
    logic [10:0]      w_bottom;
    logic             w_lava;

    cell_locator #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .BLK_W_LG2 (BLK_W_LG2),
        .BLK_H_LG2 (BLK_H_LG2),
        .TOP_Y     (TOP_Y),
        .ROW_W     (ROW_W),
        .COL_W     (COL_W)
    ) u_locator (
        .i_x        (r_cap_x),
        .i_y        (r_cap_y),
        .i_off      (r_cap_off),
        .o_row      (w_row),
        .o_col      (w_col),
        .o_in_field (w_in_field)
    );

    assign w_idx  = IDX_W'(w_row) * IDX_W'(COLS) + IDX_W'(w_col);
    assign w_mask = N'(1) << w_idx;
    assign w_hit  = r_cap_valid && w_in_field && r_bricks[w_idx] && (r_state == ST_PLAY);
    assign w_left = 6'(popcount(64'(r_bricks)));

    assign w_off_next = (r_off > 10'(1023 - STEP)) ? 10'd1023 : r_off + 10'(STEP);

    always_comb begin
        w_any    = 1'b0;
        w_lowest = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (|r_bricks[r*COLS +: COLS]) begin
                w_any    = 1'b1;
                w_lowest = ROW_W'(r);
            end
        end
    end

    // Bottom edge of the lowest populated row; 11 bits so a saturated offset cannot wrap.
    assign w_bottom = 11'(TOP_Y) + {1'b0, r_off} + ((11'(w_lowest) + 11'd1) << BLK_H_LG2);
    assign w_lava   = w_any && (w_bottom >= 11'(LAVA_Y));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bricks    <= '0;
            r_off       <= '0;
            r_cnt       <= '0;
            r_cap_valid <= 1'b0;
            r_cap_x     <= '0;
            r_cap_y     <= '0;
            r_cap_off   <= '0;
            r_hit       <= 1'b0;
            r_endgame   <= 1'b0;
        end else begin
            r_hit       <= 1'b0;
            r_cap_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bricks <= '1;
                        r_off    <= '0;
                        r_cnt    <= '0;
                        r_state  <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    // A sample arriving while the previous one hits is dropped so pulses never abut.
                    if (ball_valid && !w_hit) begin
                        r_cap_valid <= 1'b1;
                        r_cap_x     <= ball_x;
                        r_cap_y     <= ball_y;
                        r_cap_off   <= r_off;
                    end
                    if (w_hit) begin
                        r_bricks <= r_bricks & ~w_mask;
                        r_hit    <= 1'b1;
                    end
                    if (frame_tick) begin
                        if (r_cnt == CNT_W'(DESCENT_TK - 1)) begin
                            r_cnt <= '0;
                            r_off <= w_off_next;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    if (w_left == 6'd0) begin
                        r_bricks <= '1;
                        r_off    <= '0;
                        r_cnt    <= '0;
                    end else if (w_lava) begin
                        r_state   <= ST_OVER;
                        r_endgame <= 1'b1;
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        r_bricks  <= '1;
                        r_off     <= '0;
                        r_cnt     <= '0;
                        r_endgame <= 1'b0;
                        r_state   <= ST_PLAY;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign hit_block     = r_hit;
    assign bounce_y      = r_hit;
    assign endgame_block = r_endgame;
    assign bricks        = r_bricks;
    assign field_off     = r_off;
    assign bricks_left   = w_left;

endmodule
